// File: rtl/branch_state_machine.sv
// Saturating up/down counter branch predictor (single entry).
// Ports: clk, reset (sync, active-high), taken -> predict, state.
// Optional macro STATE_MACHINE_STATS_EN adds branch_count and
// mispredict_count (STAT_W, saturating, cleared on reset).
module branch_state_machine #(
  parameter int CNT_W       = 2,
  parameter int RESET_STATE = 0,
  parameter int STAT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             taken,
`ifdef STATE_MACHINE_STATS_EN
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count,
`endif
  output logic             predict,
  output logic [CNT_W-1:0] state
);

  localparam logic [CNT_W-1:0] RST_V = CNT_W'(RESET_STATE);
  localparam logic [CNT_W-1:0] MAX_V = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_max;
  logic             at_min;

  assign at_max = (cnt == MAX_V);
  assign at_min = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) cnt <= RST_V;
    else       cnt <= cnt_nxt;
  end

  // Saturate at both ends instead of wrapping.
  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      taken && !at_max:  cnt_nxt = cnt + ONE_V;
      !taken && !at_min: cnt_nxt = cnt - ONE_V;
      default:           cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    predict = cnt[CNT_W-1];
    state   = cnt;
  end

`ifdef STATE_MACHINE_STATS_EN
  localparam logic [STAT_W-1:0] SMAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] SONE = STAT_W'(1);

  logic miss;
  assign miss = (cnt[CNT_W-1] != taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (branch_count != SMAX)
        branch_count <= branch_count + SONE;
      if (miss && mispredict_count != SMAX)
        mispredict_count <= mispredict_count + SONE;
    end
  end
`endif

endmodule

// File: tb/tb_branch_state_machine.sv
// Directed scoreboard bench for branch_state_machine (CNT_W=2).
// Expected states are queued at drive time, popped after the edge.
module tb_branch_state_machine;

  logic       clk = 1'b0;
  logic       reset;
  logic       taken;
  logic       predict;
  logic [1:0] state;
`ifdef STATE_MACHINE_STATS_EN
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  branch_state_machine #(
    .CNT_W(2),
    .RESET_STATE(0),
    .STAT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .taken(taken),
`ifdef STATE_MACHINE_STATS_EN
    .branch_count(branch_count),
    .mispredict_count(mispredict_count),
`endif
    .predict(predict),
    .state(state)
  );

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag);
    logic [1:0] exp;
    logic       exp_p;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s scoreboard empty got=0 want=1", tag);
    end
    if (sb.size() != 0) begin
      exp   = sb.pop_front();
      exp_p = exp[1];
      total++;
      assert (state === exp) else begin
        bad++;
        $error("FAIL %s state got=%0d want=%0d", tag, state, exp);
      end
      total++;
      assert (predict === exp_p) else begin
        bad++;
        $error("FAIL %s predict got=%0b want=%0b", tag, predict, exp_p);
      end
    end
  endtask

  task automatic step(input logic r, input logic t,
                      input logic [1:0] exp, input string tag);
    reset = r;
    taken = t;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check(tag);
  endtask

`ifdef STATE_MACHINE_STATS_EN
  task automatic stats(input logic [15:0] eb, input logic [15:0] em,
                       input string tag);
    total++;
    assert (branch_count === eb) else begin
      bad++;
      $error("FAIL %s branch_count got=%0d want=%0d", tag, branch_count, eb);
    end
    total++;
    assert (mispredict_count === em) else begin
      bad++;
      $error("FAIL %s mispredict got=%0d want=%0d", tag, mispredict_count, em);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    taken = 1'b0;
    #1;
    // reset then saturate at 0
    step(1, 0, 2'd0, "reset");
    for (int i = 0; i < 5; i++) step(0, 0, 2'd0, "sat_lo");
    // train up from 0
    step(0, 1, 2'd1, "up1");
    step(0, 1, 2'd2, "up2");
    step(0, 1, 2'd3, "up3");
    step(0, 1, 2'd3, "sat_hi4");
    step(0, 1, 2'd3, "sat_hi5");
    // hysteresis from strong taken
    step(0, 0, 2'd2, "hyst_dn");
    step(0, 1, 2'd3, "hyst_up");
    // train down from 3
    step(0, 0, 2'd2, "dn1");
    step(0, 0, 2'd1, "dn2");
    step(0, 0, 2'd0, "dn3");
    step(0, 0, 2'd0, "dn4");
    // reset mid training at state 2
    step(0, 1, 2'd1, "mid1");
    step(0, 1, 2'd2, "mid2");
    step(1, 1, 2'd0, "mid_rst");
    step(0, 1, 2'd1, "restart1");
    step(0, 1, 2'd2, "restart2");
    // reset while taken=1 from strong taken
    step(0, 1, 2'd3, "pre_rst");
    step(1, 1, 2'd0, "rst_st");
    // stats scenario
    step(1, 0, 2'd0, "s_rst");
`ifdef STATE_MACHINE_STATS_EN
    stats(16'd0, 16'd0, "stats_rst");
`endif
    step(0, 1, 2'd1, "s1");
    step(0, 1, 2'd2, "s2");
    step(0, 1, 2'd3, "s3");
    step(0, 1, 2'd3, "s4");
    step(0, 1, 2'd3, "s5");
`ifdef STATE_MACHINE_STATS_EN
    stats(16'd5, 16'd2, "stats_run");
`endif
    step(1, 1, 2'd0, "s_rst2");
`ifdef STATE_MACHINE_STATS_EN
    stats(16'd0, 16'd0, "stats_clr");
`endif
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_state_machine.md
Name: branch_state_machine

Overview:
- Branch-direction predictor built as an N-bit saturating up/down counter FSM. Default N = 2, giving the classic 2-bit predictor.
- Every clock, the resolved branch outcome `taken` moves the counter. The counter MSB is the prediction for the next branch.
- Sits beside the fetch/branch-resolution logic as a single-entry predictor, with no table indexing.

Parameters:
- CNT_W, 2, counter width in bits. Legal range 1..8. Number of states = 2**CNT_W.
- RESET_STATE, 0, counter value loaded on reset. Must be < 2**CNT_W. Default is strongly-not-taken.
- STAT_W, 16, width of the statistics counters. Used only when STATE_MACHINE_STATS_EN is defined.

Ports:
- clk, input, 1, single clock. All state updates on its rising edge.
- reset, input, 1, synchronous, active-high. Sampled on the clk rising edge.
- taken, input, 1, resolved branch outcome for the current cycle. 1 = taken, 0 = not taken.
- predict, output, 1, current prediction. Equals the counter MSB. Driven combinationally from the state register, with no extra register stage.
- state, output, CNT_W, current counter value, for debug and observation.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- State register `cnt`, CNT_W bits, unsigned. Encoding for CNT_W=2:
  - 0 = strong not-taken (SNT)
  - 1 = weak not-taken (WNT)
  - 2 = weak taken (WT)
  - 3 = strong taken (ST)
- Reset:
  - If reset=1 at a rising edge, cnt <= RESET_STATE, regardless of `taken`.
  - With the default, predict=0 and state=0 after reset.
  - Reset has priority over every update and takes effect in the same edge even mid-training.
- Update, applied every rising edge with reset=0 (there is no valid/enable; `taken` is consumed each cycle):
  - taken=1: cnt <= cnt+1, saturating at 2**CNT_W-1 (never wraps to 0).
  - taken=0: cnt <= cnt-1, saturating at 0 (never wraps to max).
- Output: predict = cnt[CNT_W-1]. Prediction is taken when cnt >= 2**(CNT_W-1).
- Latency: `taken` affects `state` and `predict` after exactly one rising edge.
  - From reset state 0 with taken held at 1, predict goes 1 after the 2nd edge.
  - From state 3 with taken held at 0, predict goes 0 after the 2nd edge.
- Hysteresis: from a strong state, one contrary outcome moves the counter only to the weak state on the same side. The prediction does not change.
- CNT_W=1 degenerates to a last-outcome predictor: predict = previous taken.
- No X propagation: outputs are defined from the first edge with reset asserted. Before the first reset the value is undefined and does not need to be checked.

Optional Feature:
- Macro STATE_MACHINE_STATS_EN.
- When defined, add two outputs:
  - branch_count (STAT_W): increments every non-reset cycle.
  - mispredict_count (STAT_W): increments in a non-reset cycle when predict (value before the edge) != taken.
- Both counters:
  - Saturate at all-ones and do not wrap.
  - Clear to 0 on reset.
  - Are registered, so an update is visible after the edge.
- When not defined, the ports and logic are absent and the core behaviour is identical.

Test Plan:
- Reset 1 cycle with taken=0, then hold taken=0 for 5 cycles -> state=0, predict=0 throughout (saturation at 0).
- From state 0, taken=1 for 5 cycles -> state sequence 1,2,3,3,3; predict=0,1,1,1,1 after edges 1..5.
- From state 3, one taken=0, then taken=1 -> state 2 then 3; predict stays 1 (hysteresis).
- From state 3, taken=0 for 4 cycles -> state 2,1,0,0; predict 1,0,0,0.
- Assert reset in the middle of a taken=1 run while at state 2 -> next edge state=0, predict=0; training restarts from 0.
- With STATE_MACHINE_STATS_EN, from reset, the 5 taken=1 cycles above -> branch_count=5, mispredict_count=2; a further reset -> both 0.
